// File: rtl/mcpu_mem_arbiter.sv
// Arbiter that shares the MCPU single-port RAM between the CPU and the debug loader.
// The CPU has fixed priority. The loader is forced through after MAX_WAIT blocked grants.
module mcpu_mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          starved
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_LD   = 2'd2;
    localparam logic [3:0] W_MAX    = 4'(MAX_WAIT);

    logic [3:0]    r_wait_cnt;
    logic [1:0]    r_rd_owner;
    logic          w_c_gnt;
    logic          w_d_gnt;
    logic          w_starved;
    logic          w_m_we;
    logic [AW-1:0] w_m_addr;
    logic [DW-1:0] w_m_wdata;
    logic          w_c_rvalid;
    logic          w_d_rvalid;

    // Grant decision; held low during reset so nothing reaches the RAM
    always_comb begin
        w_c_gnt   = 1'b0;
        w_d_gnt   = 1'b0;
        w_starved = 1'b0;
        if (!reset) begin
            w_c_gnt   = 1'b0;
            w_d_gnt   = 1'b0;
            w_starved = 1'b0;
        end else if (c_req && (!d_req || (r_wait_cnt < W_MAX))) begin
            w_c_gnt = 1'b1;
        end else if (d_req) begin
            w_d_gnt   = 1'b1;
            // Contended loader win can only happen through the wait limit
            w_starved = c_req;
        end else begin
            w_c_gnt   = 1'b0;
            w_d_gnt   = 1'b0;
            w_starved = 1'b0;
        end
    end

    // RAM port mux: winner drives the bus, idle bus is all zero
    always_comb begin
        w_m_we    = 1'b0;
        w_m_addr  = {AW{1'b0}};
        w_m_wdata = {DW{1'b0}};
        if (w_c_gnt) begin
            w_m_we    = c_we;
            w_m_addr  = c_addr;
            w_m_wdata = c_wdata;
        end else if (w_d_gnt) begin
            w_m_we    = d_we;
            w_m_addr  = d_addr;
            w_m_wdata = d_wdata;
        end else begin
            w_m_we    = 1'b0;
            w_m_addr  = {AW{1'b0}};
            w_m_wdata = {DW{1'b0}};
        end
    end

    // Route returning read data to the requester that owns the outstanding read
    always_comb begin
        w_c_rvalid = 1'b0;
        w_d_rvalid = 1'b0;
        case (r_rd_owner)
            OWN_CPU: w_c_rvalid = 1'b1;
            OWN_LD:  w_d_rvalid = 1'b1;
            default: begin
                w_c_rvalid = 1'b0;
                w_d_rvalid = 1'b0;
            end
        endcase
    end

    // Loader wait counter and outstanding-read owner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= 4'd0;
            r_rd_owner <= OWN_NONE;
        end else begin
            if (d_req && w_c_gnt) begin
                r_wait_cnt <= (r_wait_cnt >= W_MAX) ? W_MAX : (r_wait_cnt + 4'd1);
            end else begin
                r_wait_cnt <= 4'd0;
            end
            if (w_c_gnt && !c_we) begin
                r_rd_owner <= OWN_CPU;
            end else if (w_d_gnt && !d_we) begin
                r_rd_owner <= OWN_LD;
            end else begin
                r_rd_owner <= OWN_NONE;
            end
        end
    end

    assign c_gnt    = w_c_gnt;
    assign d_gnt    = w_d_gnt;
    assign starved  = w_starved;
    assign m_en     = w_c_gnt | w_d_gnt;
    assign m_we     = w_m_we;
    assign m_addr   = w_m_addr;
    assign m_wdata  = w_m_wdata;
    assign c_rvalid = w_c_rvalid;
    assign d_rvalid = w_d_rvalid;
    assign c_rdata  = w_c_rvalid ? m_rdata : {DW{1'b0}};
    assign d_rdata  = w_d_rvalid ? m_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Self-checking bench for mcpu_mem_arbiter: a behavioural RAM, a rule-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_mcpu_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          clk;
    logic          reset;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          m_en, m_we, starved;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    int total = 0;
    int bad   = 0;

    mcpu_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .starved(starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) ram[m_addr] <= m_wdata;
            else      m_rdata <= ram[m_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: loader blocked count, memory image, pending read
    int            md_wait = 0;
    logic [DW-1:0] md_mem [256];
    int            md_pend = 0;          // 0 none, 1 cpu, 2 loader
    logic [DW-1:0] md_pdata = '0;
    logic          e_cg, e_dg, e_st, e_en, e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_c_gnt", 32'(c_gnt), 32'd0);
            chk("rst_d_gnt", 32'(d_gnt), 32'd0);
            chk("rst_starved", 32'(starved), 32'd0);
            chk("rst_m_en", 32'(m_en), 32'd0);
            chk("rst_m_bus", {15'd0, m_we, m_addr, 8'd0}, 32'd0);
            chk("rst_m_wdata", 32'(m_wdata), 32'd0);
            chk("rst_c_rv", {15'd0, c_rvalid, c_rdata}, 32'd0);
            chk("rst_d_rv", {15'd0, d_rvalid, d_rdata}, 32'd0);
            md_wait = 0;
            md_pend = 0;
        end else begin
            e_cg = c_req && (!d_req || md_wait < MW);
            e_dg = d_req && !e_cg;
            e_st = e_dg && c_req;
            e_en = e_cg || e_dg;
            e_we = e_cg ? c_we : (e_dg ? d_we : 1'b0);
            e_a  = e_cg ? c_addr : (e_dg ? d_addr : 8'h00);
            e_wd = e_cg ? c_wdata : (e_dg ? d_wdata : 16'h0000);
            chk("c_gnt", 32'(c_gnt), 32'(e_cg));
            chk("d_gnt", 32'(d_gnt), 32'(e_dg));
            chk("starved", 32'(starved), 32'(e_st));
            chk("m_en", 32'(m_en), 32'(e_en));
            chk("m_we", 32'(m_we), 32'(e_we));
            chk("m_addr", 32'(m_addr), 32'(e_a));
            chk("m_wdata", 32'(m_wdata), 32'(e_wd));
            chk("c_rvalid", 32'(c_rvalid), 32'(md_pend == 1));
            chk("d_rvalid", 32'(d_rvalid), 32'(md_pend == 2));
            chk("c_rdata", 32'(c_rdata), (md_pend == 1) ? 32'(md_pdata) : 32'd0);
            chk("d_rdata", 32'(d_rdata), (md_pend == 2) ? 32'(md_pdata) : 32'd0);
            md_pend = 0;
            if (e_en && !e_we) begin
                md_pend  = e_cg ? 1 : 2;
                md_pdata = md_mem[e_a];
            end
            if (e_en && e_we) md_mem[e_a] = e_wd;
            md_wait = (d_req && e_cg) ? ((md_wait + 1 > MW) ? MW : md_wait + 1) : 0;
        end
    end

    task automatic drv(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                       input logic dr, input logic dw, input logic [7:0] da, input logic [15:0] dd);
        @(posedge clk);
        #1;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    logic [9:0] seq_c, seq_d, seq_s;

    initial begin
        reset = 1'b0;
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h20; c_wdata = 16'h1111;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 16'h3333;
        repeat (2) begin
            @(negedge clk);
            chk("lit_rst_gnt", {30'd0, c_gnt, d_gnt}, 32'd0);
            chk("lit_rst_m_en", 32'(m_en), 32'd0);
        end
        // Release with both requesting: C,C,C,C,D pattern from the first cycle
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seq_c[i] = c_gnt;
            seq_d[i] = d_gnt;
            seq_s[i] = starved;
        end
        chk("lit_prio_c", 32'(seq_c), 32'h1EF);
        chk("lit_prio_d", 32'(seq_d), 32'h210);
        chk("lit_prio_starved", 32'(seq_s), 32'h210);
        idle();

        // Loader-only write then read
        drv(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h10, 16'h1A2B);
        @(negedge clk) chk("lit_ld_wr_gnt", 32'(d_gnt), 32'd1);
        drv(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
        @(negedge clk) chk("lit_ld_rd_gnt", 32'(d_gnt), 32'd1);
        idle();
        @(negedge clk);
        chk("lit_ld_rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd1);
        chk("lit_ld_rdata", 32'(d_rdata), 32'h1A2B);

        // Preload through the loader, then interleaved reads
        drv(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h00, 16'h1000);
        drv(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h01, 16'h2001);
        drv(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        drv(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h01, 16'h0000);
        @(negedge clk);
        chk("lit_il_c", {15'd0, c_rvalid, c_rdata}, 32'h11000);
        chk("lit_il_d_quiet", 32'(d_rvalid), 32'd0);
        idle();
        @(negedge clk);
        chk("lit_il_d", {15'd0, d_rvalid, d_rdata}, 32'h12001);
        chk("lit_il_c_quiet", 32'(c_rvalid), 32'd0);

        // CPU write followed by loader read of the same address
        drv(1'b1, 1'b1, 8'hFA, 16'h00F0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drv(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'hFA, 16'h0000);
        idle();
        @(negedge clk) chk("lit_hazard", {15'd0, d_rvalid, d_rdata}, 32'h100F0);

        // Same-address contention: CPU read wins, loader write retries
        drv(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h40, 16'h5555);
        drv(1'b1, 1'b0, 8'h40, 16'h0000, 1'b1, 1'b1, 8'h40, 16'hBEEF);
        @(negedge clk) chk("lit_cont_win", {30'd0, c_gnt, d_gnt}, 32'd2);
        drv(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h40, 16'hBEEF);
        @(negedge clk);
        chk("lit_cont_old", 32'(c_rdata), 32'h5555);
        chk("lit_cont_retry", 32'(d_gnt), 32'd1);
        drv(1'b1, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        idle();
        @(negedge clk) chk("lit_cont_new", {15'd0, c_rvalid, c_rdata}, 32'h1BEEF);

        // Reset while a CPU read is in flight
        drv(1'b1, 1'b1, 8'h50, 16'h0001, 1'b1, 1'b1, 8'h51, 16'h0002);
        drv(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk) chk("lit_mid_gnt", 32'(c_gnt), 32'd1);
        #1 reset = 1'b0;
        c_req = 1'b0;
        @(negedge clk) chk("lit_mid_rv", 32'(c_rvalid), 32'd0);
        drv(1'b1, 1'b1, 8'h60, 16'h0006, 1'b1, 1'b1, 8'h61, 16'h0007);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seq_d[i] = d_gnt;
            seq_c[i] = c_rvalid;
        end
        chk("lit_mid_seq", 32'(seq_d[4:0]), 32'h10);
        chk("lit_mid_norv", 32'(seq_c[4:0]), 32'd0);
        idle();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mcpu_mem_arbiter.md
# mcpu_mem_arbiter

Two-requester arbiter for the MCPU single-port program/data RAM. The CPU's fetch/load/store path and a debug loader port (used to preload programs and inspect memory without hierarchical pokes) share one synchronous RAM port. The CPU has fixed priority, with a bounded-wait guarantee for the loader. Read data returns one cycle after grant on a per-requester valid strobe.

## Interface

Parameters:
- AW, 8, address width (256-word RAM)
- DW, 16, data width (one MCPU instruction word)
- MAX_WAIT, 4, consecutive loader-blocked grants tolerated before the loader is forced through (1..15)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- c_req  in  1  CPU access request
- c_we  in  1  CPU write enable (1 = store, 0 = read)
- c_addr  in  AW  CPU address
- c_wdata  in  DW  CPU write data
- c_gnt  out  1  CPU request accepted this cycle
- c_rvalid  out  1  CPU read data valid
- c_rdata  out  DW  CPU read data
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  loader request, same meaning as CPU
- d_gnt, d_rvalid, d_rdata  out  1/1/DW  loader grant, read valid, read data
- m_en  out  1  RAM access enable
- m_we  out  1  RAM write enable
- m_addr  out  AW  RAM address
- m_wdata  out  DW  RAM write data
- m_rdata  in  DW  RAM read data, valid one cycle after m_en with m_we=0
- starved  out  1  high in a cycle where the loader grant is forced by MAX_WAIT

## Operation

- Arbitration is combinational from the req inputs and the registered wait_cnt. At most one gnt is high per cycle.
  - Only c_req: CPU granted.
  - Only d_req: loader granted.
  - Both, wait_cnt < MAX_WAIT: CPU granted.
  - Both, wait_cnt == MAX_WAIT: loader granted, starved=1.
- Winner's we/addr/wdata drive m_we/m_addr/m_wdata. m_en = c_gnt | d_gnt.
- Idle (no gnt): m_en=0, m_we=0, m_addr=0, m_wdata=0.
- Requester holds req/we/addr/wdata stable until it sees gnt. A request is consumed on the gnt cycle. The requester may present a new request the very next cycle.
- wait_cnt (4-bit), updated each clock:
  - d_req & c_gnt: increment, saturating at MAX_WAIT.
  - d_gnt or !d_req: clear to 0.
- rd_owner register (2 bits: none/CPU/loader) captures the owner of a granted read (we=0). A write or an idle cycle sets it to none.
- c_rvalid = (rd_owner == CPU); d_rvalid = (rd_owner == loader).
- c_rdata = m_rdata when c_rvalid, else 0. d_rdata likewise.
- Writes produce no rvalid.

## Timing

- Grant: same cycle as req (zero-latency acceptance when uncontended).
- Read latency: rvalid exactly 1 cycle after gnt. Back-to-back reads give one rvalid per cycle, in grant order.
- Write takes effect in RAM at the gnt-cycle clock edge. A read of the same address granted the next cycle returns the new data.
- Worst-case loader wait: MAX_WAIT+1 cycles under continuous CPU requests.
- Reset (reset=0, asynchronous):
  - wait_cnt=0, rd_owner=none.
  - All gnt/rvalid/rdata/m_* outputs and starved = 0, regardless of req inputs.
- Reset mid-operation: a read granted in the cycle where reset asserts yields no rvalid.
- Release: first grant is possible in the first cycle with reset=1.
- Simultaneous CPU read and loader write on the same address: only the winner accesses the RAM. The loser retries and observes the winner's effect.

## Test plan

- Reset: drive c_req=d_req=1 with reset=0 -> all gnt, rvalid, m_en = 0. Release reset -> CPU granted that cycle, wait_cnt counts.
- Loader-only write then read: d write addr 8'h10 data 16'h1A2B, then d read 8'h10 -> d_gnt both cycles, d_rvalid 1 cycle after the read grant with d_rdata=16'h1A2B, c_rvalid stays 0.
- CPU priority: c_req and d_req both held high continuously, MAX_WAIT=4 -> grants C,C,C,C,D (starved=1 on the D cycle), then C,C,C,C,D repeating.
- Interleaved reads: CPU reads 8'h00, loader reads 8'h01 in the next cycle, RAM preloaded 16'h1000/16'h2001 -> c_rvalid with 16'h1000 then d_rvalid with 16'h2001 on consecutive cycles, never both high.
- Write-then-read hazard: CPU writes 8'hFA=16'h00F0, loader reads 8'hFA in the next cycle -> d_rdata=16'h00F0.
- Reset mid-read: CPU read granted, reset asserted before the next edge -> c_rvalid never asserts, wait_cnt=0 after release.
